// File: rtl/cpu_pkg.sv
// Shared definitions for the bus CPU: control-word bit positions, loader states
// and memory geometry.
package cpu_pkg;

    localparam int CW_W     = 15;
    localparam int CP_IDX   = 14;
    localparam int EP_IDX   = 13;
    localparam int LP_IDX   = 12;
    localparam int NLMA_IDX = 11;
    localparam int NLMD_IDX = 10;
    localparam int NCE_IDX  = 9;
    localparam int NLR_IDX  = 8;
    localparam int NLI_IDX  = 7;
    localparam int NEI_IDX  = 6;
    localparam int NLA_IDX  = 5;
    localparam int EA_IDX   = 4;
    localparam int SU_IDX   = 3;
    localparam int EU_IDX   = 2;
    localparam int NLB_IDX  = 1;
    localparam int NLO_IDX  = 0;

    localparam int MEM_ADDR_W = 4;
    localparam int MEM_DATA_W = 8;
    localparam int RAM_DEPTH  = 2 ** MEM_ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } ldr_state_t;

    // Extract the four RAM-group controls (nLma, nLmd, nLr, nCE) from a control word.
    function automatic logic [3:0] ram_ctrl(input logic [CW_W-1:0] cw);
        return {cw[NLMA_IDX], cw[NLMD_IDX], cw[NLR_IDX], cw[NCE_IDX]};
    endfunction

endpackage

// File: rtl/memory_unit_ram_array.sv
// Flop-based RAM: async clear, one synchronous write port, one combinational read port.
module ram_array #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/memory_unit.sv
// RAM control group responder: MAR, flop RAM, registered MDR on the shared bus,
// plus a sequential program loader with valid/ready handshake.
//
// state | meaning
// IDLE  | CPU owns RAM; waiting for prog_mode
// LOAD  | loader owns RAM; prog_ready=1, bytes written at load_addr
// FULL  | all locations loaded; prog_done=1, further bytes ignored
module memory_unit #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  wire  [DATA_W-1:0] bus,
    input  logic              nLma,
    input  logic              nLmd,
    input  logic              nLr,
    input  logic              nCE,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              prog_done,
    output logic [ADDR_W-1:0] mar_out
);

    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    ldr_state_t        state;
    logic [ADDR_W-1:0] mar;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] ram_rdata;
    logic              ready_q;
    logic              done_q;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ldr_accept;

    assign ldr_accept = prog_mode && ready_q && prog_valid;

    // prog_mode hands the single write port to the loader; CPU writes are dropped.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = mar;
        ram_wdata = bus;
        if (prog_mode) begin
            ram_we    = ldr_accept;
            ram_waddr = load_addr;
            ram_wdata = prog_data;
        end else begin
            ram_we    = !nLmd;
        end
    end

    ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (mar),
        .rdata (ram_rdata)
    );

    // Reads and writes all use the pre-edge MAR, so nLma combined with nLmd/nLr
    // acts on the old address before MAR moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar <= '0;
            mdr <= '0;
        end else if (!prog_mode) begin
            if (!nLma) mar <= bus[ADDR_W-1:0];
            if (!nLr)  mdr <= ram_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            load_addr <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (prog_mode) begin
                        state     <= LOAD;
                        load_addr <= '0;
                        ready_q   <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!prog_mode) begin
                        state   <= IDLE;
                        ready_q <= 1'b0;
                    end else if (prog_valid) begin
                        if (load_addr == LAST_ADDR) begin
                            state     <= FULL;
                            ready_q   <= 1'b0;
                            done_q    <= 1'b1;
                            load_addr <= '0;
                        end else begin
                            load_addr <= load_addr + ADDR_ONE;
                        end
                    end
                end
                FULL: begin
                    if (!prog_mode) state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign prog_ready = ready_q;
    assign prog_done  = done_q;
    assign mar_out    = mar;

    // nLmd=0 means someone else is driving the bus for a write, so never drive then.
    assign bus = (!nCE && nLmd && !prog_mode) ? mdr : {DATA_W{1'bz}};

endmodule

// File: tb/tb_memory_unit.sv
// Scoreboard bench for memory_unit: reads push expected MDR values, bus drives pop them.
module tb_memory_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       nLma, nLmd, nLr, nCE;
    logic       prog_mode, prog_valid;
    logic [7:0] prog_data;
    wire        prog_ready, prog_done;
    wire  [3:0] mar_out;
    wire  [7:0] bus;
    logic       tb_drv;
    logic [7:0] tb_val;

    always #5 clk = ~clk;

    assign bus = tb_drv ? tb_val : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (bus[g]);
    end

    memory_unit #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .nLma       (nLma),
        .nLmd       (nLmd),
        .nLr        (nLr),
        .nCE        (nCE),
        .prog_mode  (prog_mode),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_ready (prog_ready),
        .prog_done  (prog_done),
        .mar_out    (mar_out)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_ram [16];
    logic [3:0] m_mar;
    logic [7:0] m_mdr;
    logic [7:0] sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_ctrl();
        nLma = 1'b1; nLmd = 1'b1; nLr = 1'b1; nCE = 1'b1;
        tb_drv = 1'b0; tb_val = 8'h00;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
        m_mar = 4'h0;
        m_mdr = 8'h00;
        sb.delete();
    endtask

    // One CPU-mode cycle; the DUT must not be driving the bus (nCE=1 or nLmd=0).
    task automatic cpu_cycle(input logic lma, input logic lmd, input logic lr,
                             input logic ce, input logic drv, input logic [7:0] val);
        logic [7:0] busv;
        logic [3:0] old_mar;
        nLma = lma; nLmd = lmd; nLr = lr; nCE = ce;
        tb_drv = drv; tb_val = val;
        busv = drv ? val : 8'hFF;
        old_mar = m_mar;
        if (!lr) begin
            m_mdr = m_ram[old_mar];
            sb.push_back(m_mdr);
        end
        if (!lmd) m_ram[old_mar] = busv;
        if (!lma) m_mar = busv[3:0];
        @(posedge clk); #1;
        idle_ctrl();
        check("mar_track", {28'h0, mar_out}, {28'h0, m_mar});
    endtask

    task automatic show_mdr(input string tag);
        logic [7:0] exp;
        nCE = 1'b0;
        #2;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb.pop_front();
            check(tag, {24'h0, bus}, {24'h0, exp});
        end
        nCE = 1'b1;
        #1;
        check({tag, "_release"}, {24'h0, bus}, 32'hFF);
        @(posedge clk); #1;
    endtask

    task automatic read_addr(input logic [3:0] a, input string tag);
        cpu_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, {4'h0, a});
        cpu_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        show_mdr(tag);
    endtask

    initial begin
        int  rdy_cnt;
        int  idx;
        logic rdy;

        rst_n = 1'b0;
        idle_ctrl();
        prog_mode = 1'b0; prog_valid = 1'b0; prog_data = 8'h00;
        model_reset();
        #12;
        check("rst_mar",   {28'h0, mar_out}, 32'h0);
        check("rst_ready", {31'h0, prog_ready}, 32'h0);
        check("rst_done",  {31'h0, prog_done}, 32'h0);
        check("rst_bus_z", {24'h0, bus}, 32'hFF);
        nCE = 1'b0; #1;
        check("rst_mdr", {24'h0, bus}, 32'h00);
        nCE = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        cpu_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03);
        cpu_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A);
        cpu_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        show_mdr("wr_rd3");

        // Reset in the middle of a program load.
        prog_mode = 1'b1; prog_valid = 1'b1; prog_data = 8'h99;
        repeat (4) @(posedge clk);
        #1;
        check("mid_ready", {31'h0, prog_ready}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_mar",   {28'h0, mar_out}, 32'h0);
        check("mrst_ready", {31'h0, prog_ready}, 32'h0);
        check("mrst_done",  {31'h0, prog_done}, 32'h0);
        prog_mode = 1'b0; prog_valid = 1'b0;
        nCE = 1'b0; #1;
        check("mrst_mdr", {24'h0, bus}, 32'h00);
        nCE = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        read_addr(4'h3, "mrst_ram3");
        read_addr(4'h0, "mrst_ram0");

        // Full 16-byte load with valid held high, then an ignored 17th byte.
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h10 + 8'(i);
        prog_mode = 1'b1; prog_valid = 1'b1;
        rdy_cnt = 0; idx = 0;
        for (int c = 0; c < 22; c++) begin
            rdy = prog_ready;
            if (rdy) rdy_cnt++;
            prog_data = (idx < 16) ? (8'h10 + 8'(idx)) : 8'hAA;
            @(posedge clk); #1;
            if (rdy) idx++;
        end
        check("ready_cycles", rdy_cnt, 32'd16);
        check("full_done",  {31'h0, prog_done}, 32'h1);
        check("full_ready", {31'h0, prog_ready}, 32'h0);
        prog_mode = 1'b0; prog_valid = 1'b0;
        @(posedge clk); #1;
        check("done_hold", {31'h0, prog_done}, 32'h1);
        read_addr(4'h0, "load_ram0");
        read_addr(4'hF, "load_ram15");

        // Stalled handshake: valid every other cycle for 4 bytes.
        prog_mode = 1'b1;
        @(posedge clk); #1;
        check("entry_done",  {31'h0, prog_done}, 32'h0);
        check("entry_ready", {31'h0, prog_ready}, 32'h1);
        for (int k = 0; k < 8; k++) begin
            prog_valid = (k % 2 == 0);
            prog_data  = prog_valid ? (8'h40 + 8'(k / 2)) : 8'hEE;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) m_ram[i] = 8'h40 + 8'(i);
        check("stall_ready", {31'h0, prog_ready}, 32'h1);
        prog_mode = 1'b0; prog_valid = 1'b0;
        @(posedge clk); #1;
        check("partial_done", {31'h0, prog_done}, 32'h0);
        prog_mode = 1'b1;
        @(posedge clk); #1;
        prog_valid = 1'b1; prog_data = 8'h50;
        @(posedge clk); #1;
        m_ram[0] = 8'h50;
        prog_valid = 1'b0; prog_mode = 1'b0;
        @(posedge clk); #1;
        read_addr(4'h0, "restart_ram0");
        read_addr(4'h1, "stall_ram1");
        read_addr(4'h4, "stall_ram4");

        // CPU read of address 5.
        cpu_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05);
        cpu_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check("rd5_mar", {28'h0, mar_out}, 32'h5);
        show_mdr("rd5");

        // Write and read in the same cycle: read sees the old contents.
        cpu_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3);
        show_mdr("rbw_old");
        cpu_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        show_mdr("rbw_new");

        // nCE with nLmd low must not drive; the pulled-up bus gets written.
        nLmd = 1'b0; nCE = 1'b0; tb_drv = 1'b0;
        #2;
        check("guard_bus", {24'h0, bus}, 32'hFF);
        m_ram[m_mar] = 8'hFF;
        @(posedge clk); #1;
        idle_ctrl();
        cpu_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hF7);
        check("mar_f7", {28'h0, mar_out}, 32'h7);

        // CPU controls are ignored in program mode.
        prog_mode = 1'b1; prog_valid = 1'b0;
        nCE = 1'b0;
        #2;
        check("pm_bus", {24'h0, bus}, 32'hFF);
        @(posedge clk); #1;
        nCE = 1'b1; nLma = 1'b0; nLmd = 1'b0; nLr = 1'b0;
        tb_drv = 1'b1; tb_val = 8'h02;
        @(posedge clk); #1;
        idle_ctrl();
        prog_mode = 1'b0;
        @(posedge clk); #1;
        check("pm_mar", {28'h0, mar_out}, 32'h7);
        sb.push_back(m_mdr);
        show_mdr("pm_mdr");
        read_addr(4'h7, "pm_ram7");
        read_addr(4'h2, "pm_ram2");
        read_addr(4'h5, "guard_ram5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_unit.md
Name: memory_unit

Overview:
- Responder side of the control sequencer's RAM control group (nLma, nLmd, nLr, nCE): memory address register (MAR), 16x8 flop RAM, and a registered memory data register (MDR) that drives the shared 8-bit bus.
- A program-load port with a valid/ready handshake fills RAM sequentially from pins before the CPU runs.
- Sits beside the program counter, instruction register and accumulator on the common bus.

Parameters:
- ADDR_W, 4, address width; RAM depth is 2**ADDR_W.
- DATA_W, 8, data/bus width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- bus  inout  DATA_W  shared CPU bus; high-Z unless this block drives it.
- nLma  input  1  active-low: load MAR from bus[ADDR_W-1:0].
- nLmd  input  1  active-low: write bus into RAM[MAR].
- nLr  input  1  active-low: latch RAM[MAR] into MDR.
- nCE  input  1  active-low: drive MDR onto bus.
- prog_mode  input  1  1 = loader owns RAM; CPU controls ignored.
- prog_valid  input  1  loader byte valid.
- prog_data  input  DATA_W  loader byte.
- prog_ready  output  1  block accepts prog_data this cycle.
- prog_done  output  1  all 2**ADDR_W locations loaded.
- mar_out  output  ADDR_W  current MAR, for debug pins.

Behaviour:
- Reset (async, rst_n=0):
  - MAR=0, MDR=0, every RAM word=0, load address=0.
  - Loader FSM=IDLE, prog_ready=0, prog_done=0, bus high-Z.
- CPU mode (prog_mode=0). All updates on the rising clk edge:
  - nLma=0: MAR <= bus[ADDR_W-1:0]; upper bus bits are ignored.
  - nLmd=0: RAM[MAR] <= bus, using the MAR value held before the edge.
  - nLr=0: MDR <= RAM[MAR], using the pre-edge contents (read-before-write).
  - Read latency: nLr in cycle N, data on bus from cycle N+1 while nCE=0.
  - Bus drive is combinational: bus = MDR when nCE=0 AND nLmd=1 AND prog_mode=0, else high-Z. nLmd=0 always suppresses drive, so the block never reads and drives the bus in the same cycle.
  - nLma and nLmd together: write goes to the old MAR, then MAR updates.
  - nLma and nLr together: MDR reads the old MAR, then MAR updates.
- Loader FSM states: IDLE, LOAD, FULL.
  - IDLE -> LOAD when prog_mode=1. On entry, load address=0 and prog_done=0.
  - LOAD: prog_ready=1. When prog_valid=1 and prog_ready=1 at an edge:
    - RAM[load address] <= prog_data.
    - If load address = 2**ADDR_W-1: go to FULL, set prog_done=1, load address wraps to 0.
    - Otherwise load address increments.
  - FULL: prog_ready=0, prog_done=1, further prog_valid is ignored.
  - LOAD or FULL -> IDLE when prog_mode=0. prog_done holds its value until the next entry to LOAD or reset.
  - prog_mode falling mid-load: the partial load is kept, prog_done stays 0, and the next entry restarts at address 0.
  - While prog_mode=1: nLma, nLmd, nLr and nCE have no effect, MAR and MDR hold, bus is high-Z.
- Reset mid-load: everything returns to reset values immediately; RAM is cleared.
- mar_out = MAR, combinational from the register.

Decomposition:
- Shared package cpu_pkg holds:
  - control-word bit indices (CP_IDX=14, EP_IDX=13, LP_IDX=12, NLMA_IDX=11, NLMD_IDX=10, NCE_IDX=9, NLR_IDX=8, ... NLO_IDX=0);
  - the loader state enum {IDLE, LOAD, FULL};
  - RAM_DEPTH.
- One sub-module, ram_array: 2**ADDR_W x DATA_W flops with async clear, one synchronous write port, one combinational read port (read address and data).
- The write port is muxed between loader and CPU by prog_mode.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> MAR=0, MDR=0, prog_ready=0, prog_done=0, bus high-Z; a later read of any address returns 0x00.
- Program load: prog_mode=1; stream 16 bytes 0x10..0x1F with prog_valid held high -> prog_ready high for exactly 16 cycles, then prog_done=1, prog_ready=0. A 17th byte (0xAA) is ignored: RAM[0]=0x10 afterwards.
- Handshake stall: toggle prog_valid 1/0 every other cycle for 4 bytes -> only bytes with valid&ready are written (addresses 0..3). Drop prog_mode, re-enter -> loading restarts at address 0 and prog_done=0.
- CPU read:
  - Cycle 1: bus=0x05, nLma=0.
  - Cycle 2: nLr=0.
  - Cycle 3: nCE=0 -> bus=RAM[5] (0x15 after the load above), mar_out=5; bus high-Z once nCE=1.
- CPU write then read, same MAR: nLmd=0 with bus=0xC3 and nLr=0 in the same cycle -> MDR gets the old value (0x15); a second nLr -> MDR=0xC3.
- Contention guard: nCE=0 with nLmd=0 -> block does not drive the bus. nLma=0 with bus=0xF7 -> MAR=7 (upper nibble ignored). Any CPU controls while prog_mode=1 -> no change to MAR, MDR or RAM.
